// File: rtl/aes_v2_pkg.sv
// Shared types and helpers for the AES v2 round sequencer.
package aes_v2_pkg;

    localparam int AES_V2_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_MIX  = 2'd2,
        ST_RESP = 2'd3
    } seq_state_t;

    typedef logic [1:0] word_idx_t;

    function automatic logic [31:0] get_word(input logic [127:0] v, input word_idx_t i);
        return v[int'(i)*32 +: 32];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/aes_v2_seq_opsel.sv
// Operand selection for the round sequencer: picks the FU source words
// from the captured state/round key (SUB) or the working words (MIX).
module aes_v2_seq_opsel
    import aes_v2_pkg::*;
(
    input  seq_state_t    i_phase,
    input  word_idx_t     i_idx,
    input  logic [127:0]  i_state,
    input  logic [127:0]  i_rkey,
    input  logic [127:0]  i_tmp,
    input  logic [31:0]   i_shadow,
    output logic [31:0]   o_rs1,
    output logic [31:0]   o_rs2
);

    word_idx_t w_idx_nxt;
    assign w_idx_nxt = word_idx_t'(i_idx + 2'd1);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_rs1 = '0;
        o_rs2 = '0;
        case (i_phase)
            ST_SUB: begin
                o_rs1 = get_word(i_state, i_idx);
                o_rs2 = get_word(i_rkey, i_idx);
            end
            ST_MIX: begin
                o_rs1 = get_word(i_tmp, i_idx);
                // word 0 has already been overwritten by the time word 3 is mixed
                o_rs2 = (i_idx == 2'd3) ? i_shadow : get_word(i_tmp, w_idx_nxt);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/aes_v2_round_seq.sv
// AES v2 round sequencer: runs 4 SUB ops (and 4 MIX ops unless last) on an
// external FU. Optional latency counter under AES_V2_SEQ_CYCLE_COUNT_EN.
module aes_v2_round_seq
    import aes_v2_pkg::*;
(
    input  logic          g_clk,
    input  logic          g_rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [127:0]  req_state,
    input  logic [127:0]  req_rkey,
    input  logic          req_enc,
    input  logic          req_last,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [127:0]  rsp_state,
    output logic          fu_valid,
    output logic          fu_sub,
    output logic [31:0]   fu_rs1,
    output logic [31:0]   fu_rs2,
    output logic          fu_enc,
    output logic          fu_rot,
    input  logic          fu_ready,
    input  logic [31:0]   fu_rd,
    output logic [15:0]   busy_cycles
);

    seq_state_t   r_state, w_next_state;
    word_idx_t    r_idx;
    logic [127:0] r_st, r_rkey;
    logic         r_enc, r_last;
    logic [31:0]  r_tmp [AES_V2_WORDS];
    logic [31:0]  r_shadow;
    logic [127:0] w_tmp_flat;
    logic         w_accept, w_fire, w_rsp_hs;

    assign w_tmp_flat = {r_tmp[3], r_tmp[2], r_tmp[1], r_tmp[0]};
    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_fire     = fu_valid && fu_ready;
    assign w_rsp_hs   = (r_state == ST_RESP) && rsp_ready;
    assign rsp_state  = w_tmp_flat;

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        fu_valid     = 1'b0;
        fu_sub       = 1'b0;
        fu_rot       = 1'b0;
        fu_enc       = r_enc;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next_state = ST_SUB;
            end
            ST_SUB: begin
                fu_valid = 1'b1;
                fu_sub   = 1'b1;
                if (fu_ready && r_idx == 2'd3) w_next_state = r_last ? ST_RESP : ST_MIX;
            end
            ST_MIX: begin
                fu_valid = 1'b1;
                fu_rot   = 1'b1;
                if (fu_ready && r_idx == 2'd3) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_st     <= '0;
            r_rkey   <= '0;
            r_enc    <= 1'b0;
            r_last   <= 1'b0;
            r_shadow <= '0;
            // NOTE: the 4-word working store is reset because rsp_state must read zero after reset.
            for (int i = 0; i < AES_V2_WORDS; i++) r_tmp[i] <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_st   <= req_state;
                r_rkey <= req_rkey;
                r_enc  <= req_enc;
                r_last <= req_last;
                r_idx  <= '0;
            end
            if (w_fire) begin
                r_tmp[r_idx] <= fu_rd;
                r_idx        <= word_idx_t'(r_idx + 2'd1);
                if (r_state == ST_SUB && r_idx == 2'd0) r_shadow <= fu_rd;
            end
        end
    end

    aes_v2_seq_opsel u_opsel (
        .i_phase  (r_state),
        .i_idx    (r_idx),
        .i_state  (r_st),
        .i_rkey   (r_rkey),
        .i_tmp    (w_tmp_flat),
        .i_shadow (r_shadow),
        .o_rs1    (fu_rs1),
        .o_rs2    (fu_rs2)
    );

`ifdef AES_V2_SEQ_CYCLE_COUNT_EN
    logic [15:0] r_cnt, r_busy;

    // the handshake cycle itself is included in the latched latency
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            r_cnt  <= '0;
            r_busy <= '0;
        end else begin
            if (w_accept) r_cnt <= '0;
            else if (r_state != ST_IDLE) r_cnt <= sat_inc16(r_cnt);
            if (w_rsp_hs) r_busy <= sat_inc16(r_cnt);
        end
    end

    assign busy_cycles = r_busy;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_aes_v2_round_seq.sv
// Self-checking bench for aes_v2_round_seq with a latency-programmable FU model
// (rd = rs1^rs2 for sub, rs1+rs2 for mix).
module tb_aes_v2_round_seq;

    logic         g_clk, g_rst;
    logic         req_valid, req_ready, req_enc, req_last;
    logic [127:0] req_state, req_rkey;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_state;
    logic         fu_valid, fu_sub, fu_enc, fu_rot, fu_ready;
    logic [31:0]  fu_rs1, fu_rs2, fu_rd;
    logic [15:0]  busy_cycles;

`ifdef AES_V2_SEQ_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    aes_v2_round_seq dut (
        .g_clk       (g_clk),
        .g_rst       (g_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_state   (req_state),
        .req_rkey    (req_rkey),
        .req_enc     (req_enc),
        .req_last    (req_last),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_state   (rsp_state),
        .fu_valid    (fu_valid),
        .fu_sub      (fu_sub),
        .fu_rs1      (fu_rs1),
        .fu_rs2      (fu_rs2),
        .fu_enc      (fu_enc),
        .fu_rot      (fu_rot),
        .fu_ready    (fu_ready),
        .fu_rd       (fu_rd),
        .busy_cycles (busy_cycles)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_err    = 0;

    // FU model controls (written by the main sequence) and statistics (written by the model)
    int   fu_lat = 1;
    logic exp_enc = 1'b1;
    logic fu_force_ready = 1'b0;
    int   sub_fires = 0, mix_fires = 0, stall_viol = 0, op_viol = 0;

    typedef struct {
        logic [127:0] state;
        logic [127:0] rkey;
        logic         enc;
        logic         last;
        int           lat;
        logic [127:0] exp_state;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FU model: acts 1 time unit after each falling edge, well away from the rising edge
    initial begin : fu_model
        int fu_wait;
        logic [31:0] sv_rs1, sv_rs2;
        logic sv_sub, sv_enc;
        fu_wait = 0;
        sv_rs1 = '0; sv_rs2 = '0; sv_sub = 1'b0; sv_enc = 1'b0;
        fu_ready = 1'b0;
        fu_rd = 32'hDEAD_BEEF;
        forever begin
            @(negedge g_clk);
            #1;
            if (!fu_valid) begin
                fu_ready = fu_force_ready;
                fu_rd    = 32'hDEAD_BEEF;
                fu_wait  = 0;
            end else begin
                if (fu_wait == 0) begin
                    sv_rs1 = fu_rs1; sv_rs2 = fu_rs2; sv_sub = fu_sub; sv_enc = fu_enc;
                end else if ({fu_rs1, fu_rs2, fu_sub, fu_enc} !== {sv_rs1, sv_rs2, sv_sub, sv_enc}) begin
                    stall_viol++;
                end
                if (fu_enc !== exp_enc || (fu_sub && fu_rot !== 1'b0)) op_viol++;
                fu_wait++;
                if (fu_wait >= fu_lat) begin
                    fu_ready = 1'b1;
                    fu_rd    = fu_sub ? (fu_rs1 ^ fu_rs2) : (fu_rs1 + fu_rs2);
                    if (fu_sub) sub_fires++;
                    else mix_fires++;
                    fu_wait = 0;
                end else begin
                    fu_ready = 1'b0;
                    fu_rd    = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Issue one request and wait for rsp_valid; cycles = index of first RESP cycle (accept = 0)
    task automatic run_req(input vec_t v, output int cycles);
        fu_lat  = v.lat;
        exp_enc = v.enc;
        @(negedge g_clk);
        req_valid = 1'b1;
        req_state = v.state;
        req_rkey  = v.rkey;
        req_enc   = v.enc;
        req_last  = v.last;
        check("req_ready_before_accept", 128'(req_ready), 128'(1));
        @(negedge g_clk);
        req_valid = 1'b0;
        cycles = 1;
        while (!rsp_valid && cycles < 200) begin
            @(negedge g_clk);
            cycles++;
        end
    endtask

    task automatic finish_rsp(input int exp_busy);
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 128'(rsp_valid), 128'(0));
        check("req_ready_after_hs", 128'(req_ready), 128'(1));
        check("busy_cycles", 128'(busy_cycles), 128'(exp_busy));
    endtask

    initial begin : main
        int cyc, base_sub, base_mix;
        logic ok;

        vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, {4{32'hFFFFFFFF}}, 1'b1, 1'b1, 1,
                    128'hFFEEDDCC_BBAA9988_77665544_33221100, 5};
        vecs[1] = '{128'h00000004_00000003_00000002_00000001, 128'h0, 1'b1, 1'b0, 1,
                    128'h00000005_00000007_00000005_00000003, 9};
        vecs[2] = '{128'h0000000F_000000F0_00000F00_0000F000, {4{32'h01010101}}, 1'b0, 1'b1, 3,
                    128'h0101010E_010101F1_01010E01_0101F101, 13};
        vecs[3] = '{128'h00000040_00000030_00000020_00000010, 128'h00000004_00000003_00000002_00000001,
                    1'b1, 1'b0, 2, 128'h00000055_00000077_00000055_00000033, 17};
        vecs[4] = '{128'h80000000_80000000_00000001_FFFFFFFF, 128'h0, 1'b0, 1'b0, 1,
                    128'h7FFFFFFF_00000000_80000001_00000000, 9};

        g_rst = 1'b1;
        req_valid = 1'b0; req_state = '0; req_rkey = '0; req_enc = 1'b0; req_last = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge g_clk);
        g_rst = 1'b0;
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_fu_valid", 128'(fu_valid), 128'(0));
        check("rst_rsp_state", rsp_state, 128'h0);
        check("rst_busy_cycles", 128'(busy_cycles), 128'(0));

        for (int i = 0; i < 5; i++) begin
            base_sub = sub_fires;
            base_mix = mix_fires;
            run_req(vecs[i], cyc);
            check($sformatf("v%0d_latency", i), 128'(cyc), 128'(vecs[i].exp_cycles));
            check($sformatf("v%0d_rsp_state", i), rsp_state, vecs[i].exp_state);
            check($sformatf("v%0d_sub_ops", i), 128'(sub_fires - base_sub), 128'(4));
            check($sformatf("v%0d_mix_ops", i), 128'(mix_fires - base_mix),
                  128'(vecs[i].last ? 0 : 4));
            check($sformatf("v%0d_stall_stable", i), 128'(stall_viol), 128'(0));
            check($sformatf("v%0d_op_fields", i), 128'(op_viol), 128'(0));
            finish_rsp(CNT_EN ? vecs[i].exp_cycles : 0);
        end

        // Response backpressure: hold rsp_ready low for 10 cycles
        run_req(vecs[0], cyc);
        check("bp_latency", 128'(cyc), 128'(5));
        for (int k = 0; k < 10; k++) begin
            @(negedge g_clk);
            ok = rsp_valid && !req_ready && !fu_valid && (rsp_state === vecs[0].exp_state);
            check($sformatf("bp_hold_%0d", k), 128'(ok), 128'(1));
        end
        finish_rsp(CNT_EN ? 15 : 0);

        // Reset during the 2nd MIX op, then a stray fu_ready while idle
        fu_lat  = 1;
        exp_enc = 1'b1;
        @(negedge g_clk);
        req_valid = 1'b1;
        req_state = vecs[1].state;
        req_rkey  = vecs[1].rkey;
        req_enc   = 1'b1;
        req_last  = 1'b0;
        @(negedge g_clk);
        req_valid = 1'b0;
        repeat (5) @(negedge g_clk);
        ok = fu_valid && !fu_sub && (fu_rs1 == 32'd2) && (fu_rs2 == 32'd3);
        check("mix2_operands", 128'(ok), 128'(1));
        g_rst = 1'b1;
        @(negedge g_clk);
        g_rst = 1'b0;
        check("midrst_fu_valid", 128'(fu_valid), 128'(0));
        check("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("midrst_req_ready", 128'(req_ready), 128'(1));
        check("midrst_rsp_state", rsp_state, 128'h0);
        check("midrst_busy", 128'(busy_cycles), 128'(0));
        fu_force_ready = 1'b1;
        repeat (3) @(negedge g_clk);
        fu_force_ready = 1'b0;
        ok = !fu_valid && req_ready && !rsp_valid && (rsp_state === 128'h0);
        check("stray_fu_ready_ignored", 128'(ok), 128'(1));

        base_sub = sub_fires;
        base_mix = mix_fires;
        run_req(vecs[1], cyc);
        check("postrst_latency", 128'(cyc), 128'(9));
        check("postrst_rsp_state", rsp_state, vecs[1].exp_state);
        check("postrst_ops", 128'((sub_fires - base_sub) + (mix_fires - base_mix)), 128'(8));
        finish_rsp(CNT_EN ? 9 : 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_v2_round_seq.md
AES_V2_ROUND_SEQ -- requirements
Module: aes_v2_round_seq

Interface
REQ-001 SHALL have ports in this order: g_clk in 1, clock; g_rst in 1, reset.
- One clock.
- Reset is synchronous and active-high.
REQ-002 SHALL have the upstream request ports:
- req_valid in 1, round request valid
- req_ready out 1, sequencer can accept
- req_state in 128, AES state, word i = bits [32i+31:32i]
- req_rkey in 128, round key, same word order
- req_enc in 1, encrypt (1) / decrypt (0)
- req_last in 1, final round, skip mix phase
REQ-003 SHALL have the response ports:
- rsp_valid out 1, result valid
- rsp_ready in 1, consumer accepts
- rsp_state out 128, round result
REQ-004 SHALL have the functional-unit initiator ports:
- fu_valid out 1; fu_sub out 1; fu_rs1 out 32; fu_rs2 out 32; fu_enc out 1; fu_rot out 1
- fu_ready in 1; fu_rd in 32
REQ-005 SHALL have the port busy_cycles out 16, saturating latency of the last completed request.

Function
REQ-006 SHALL implement FSM states IDLE, SUB, MIX, RESP, with a 2-bit word index idx.
REQ-007 SHALL assert req_ready only in IDLE.
- A request is accepted when req_valid && req_ready.
- On acceptance: capture state, rkey, enc, last; idx <= 0; go to SUB.
REQ-008 In SUB, each op SHALL drive:
- fu_valid=1, fu_sub=1, fu_rot=0
- fu_rs1=state[idx], fu_rs2=rkey[idx], fu_enc=captured enc
REQ-009 In MIX, each op SHALL drive:
- fu_valid=1, fu_sub=0
- fu_rs1=tmp[idx], fu_rs2=tmp[(idx+1) mod 4], fu_enc=captured enc
REQ-010 An op SHALL complete on a cycle with fu_valid && fu_ready.
- fu_rd is written to tmp[idx] that cycle.
- idx increments modulo 4.
- fu_rs1/fu_rs2/fu_sub/fu_enc SHALL be stable while fu_valid=1 and fu_ready=0.
REQ-011 SHALL accept fu_ready high in the first cycle of fu_valid, giving a minimum of 1 cycle per op.
- fu_ready while fu_valid=0 SHALL be ignored.
REQ-012 SUB phase transitions after the op completing with idx==3:
- to MIX if last==0
- to RESP if last==1
REQ-013 MIX phase SHALL read tmp words not yet overwritten in this phase.
- Operands for idx==3 use tmp[0] as captured from SUB, held in a 32-bit shadow register.
- After idx==3 completes, go to RESP.
REQ-014 In RESP, rsp_valid=1 and rsp_state={tmp[3],tmp[2],tmp[1],tmp[0]}, held stable until rsp_ready.
- rsp_valid && rsp_ready returns to IDLE.
- A new request is not accepted in the same cycle.
REQ-015 fu_valid SHALL be 0 in IDLE and RESP.
- fu_valid SHALL stay 1 across back-to-back ops with no bubble.
REQ-016 Latency from accept to first rsp_valid SHALL be 1 + sum of op cycles.
- Minimum 5 cycles with last=1, 9 cycles with last=0.

Reset
REQ-017 g_rst high on a rising edge SHALL force IDLE, including mid-operation.
- Reset values: req_ready=1 after release, rsp_valid=0, fu_valid=0, idx=0, tmp=0, rsp_state=0, busy_cycles=0.
- An in-flight FU op is abandoned; a late fu_ready after reset is ignored.

Configuration
REQ-018 Macro AES_V2_SEQ_CYCLE_COUNT_EN defined:
- A 16-bit counter clears on accept and increments each cycle until rsp_valid && rsp_ready.
- It saturates at 16'hFFFF.
- Its value is latched to busy_cycles on response handshake.
- Undefined: busy_cycles is tied to 0 and no counter flops exist.

Structure
REQ-019 The shared package aes_v2_pkg SHALL hold:
- state enum type
- word-index type
- constant AES_V2_WORDS=4
REQ-020 Sub-module aes_v2_seq_opsel SHALL hold operand selection as combinational mux logic from phase/idx/state/rkey/tmp to fu_rs1/fu_rs2.
- The FSM, handshakes and storage stay in the top.

Verification
REQ-021 The bench FU model SHALL return rd = rs1^rs2 for sub and rd = rs1+rs2 for mix.
- Latency is programmable.
REQ-022 Scenarios:
- last=1, state=0x00112233_44556677_8899AABB_CCDDEEFF, rkey=all 0xFFFFFFFF, FU latency 1 -> rsp_state=0xFFEEDDCC_BBAA9988_77665544_33221100, rsp_valid at cycle 5.
- last=0, state=words{1,2,3,4} (word0=1), rkey=0 -> tmp after SUB {1,2,3,4}; rsp_state words {3,5,7,5}; rsp_valid at cycle 9.
- FU latency 3 with fu_ready pulses -> operands stable while stalled; 4 SUB ops only; no duplicate writes.
- rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_state stable; req_ready=0 throughout.
- g_rst asserted during 2nd MIX op -> next cycle IDLE, fu_valid=0, rsp_valid=0; following request completes correctly.
- Macro defined, FU latency 2, last=0 -> busy_cycles=17; macro undefined -> busy_cycles=0.
